turn_signal_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the tail-light sequencer FSM.
- Takes raw, asynchronous, bouncing turn-switch inputs, synchronises and debounces them, and arbitrates so at most one side is enabled.
- Drives the sequencer's eLeft/eRight enables as clean, glitch-free registered levels.

---
 rtl/turn_signal_conditioner_if.sv | 11 +
 rtl/turn_signal_conditioner.sv | 148 ++++++++++++++
 tb/tb_turn_signal_conditioner.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/turn_signal_conditioner_if.sv
// Turn-switch conditioner bus: raw switch inputs in, arbitrated enables and blocked pulse out.
interface turn_signal_conditioner_if;
  logic btnLeft;
  logic btnRight;
  logic eLeft;
  logic eRight;
  logic blocked;

  modport master (output btnLeft, output btnRight, input eLeft, input eRight, input blocked);
  modport slave  (input btnLeft, input btnRight, output eLeft, output eRight, output blocked);
endinterface

// File: rtl/turn_signal_conditioner.sv
// Synchronises, debounces and arbitrates the raw turn switches into one-hot
// registered enables for the tail-light sequencer.
module turn_signal_conditioner #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  turn_signal_conditioner_if.slave  bus
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  localparam logic [1:0] S_NONE  = 2'b00;
  localparam logic [1:0] S_LEFT  = 2'b01;
  localparam logic [1:0] S_RIGHT = 2'b10;

  logic [1:0] r_sync_l;
  logic [1:0] r_sync_r;
  logic [1:0] w_s2;
  logic [1:0] w_deb;
  logic [1:0] w_rise;
  logic       w_tick;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       w_blocked_nxt;
  logic       r_e_left;
  logic       r_e_right;
  logic       r_blocked;

  // Two-flop synchronisers; only the second stage is used downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_l <= 2'b00;
      r_sync_r <= 2'b00;
    end else begin
      r_sync_l <= {r_sync_l[0], bus.btnLeft};
      r_sync_r <= {r_sync_r[0], bus.btnRight};
    end
  end

  assign w_s2 = {r_sync_r[1], r_sync_l[1]};

  if (DIV > 1) begin : g_pre
    logic [PW-1:0] r_pre;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_pre <= '0;
      end else if (r_pre == PW'(DIV - 1)) begin
        r_pre <= '0;
      end else begin
        r_pre <= r_pre + PW'(1);
      end
    end

    assign w_tick = (r_pre == PW'(DIV - 1));
  end else begin : g_nopre
    assign w_tick = 1'b1;
  end

  // Index 0 is the left side, index 1 the right side.
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_deb;
    logic          w_deb_nxt;

    always_comb begin
      w_cnt_nxt = r_cnt;
      w_deb_nxt = r_deb;
      if (w_tick) begin
        if (w_s2[i] == r_deb) begin
          w_cnt_nxt = '0;
        end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
          w_deb_nxt = w_s2[i];
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
        r_deb <= 1'b0;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_deb <= w_deb_nxt;
      end
    end

    assign w_deb[i]  = r_deb;
    assign w_rise[i] = w_deb_nxt & ~r_deb;
  end

  // Ownership: first debounced request wins, left on a tie; always back through NONE.
  always_comb begin
    w_state_nxt   = r_state;
    w_blocked_nxt = 1'b0;
    case (r_state)
      S_NONE: begin
        if (w_deb[0]) begin
          w_state_nxt = S_LEFT;
        end else if (w_deb[1]) begin
          w_state_nxt = S_RIGHT;
        end
      end
      S_LEFT: begin
        if (!w_deb[0]) begin
          w_state_nxt = S_NONE;
        end
        w_blocked_nxt = w_rise[1];
      end
      S_RIGHT: begin
        if (!w_deb[1]) begin
          w_state_nxt = S_NONE;
        end
        w_blocked_nxt = w_rise[0];
      end
      default: begin
        w_state_nxt = S_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_NONE;
      r_e_left  <= 1'b0;
      r_e_right <= 1'b0;
      r_blocked <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_e_left  <= (w_state_nxt == S_LEFT);
      r_e_right <= (w_state_nxt == S_RIGHT);
      r_blocked <= w_blocked_nxt;
    end
  end

  assign bus.eLeft   = r_e_left;
  assign bus.eRight  = r_e_right;
  assign bus.blocked = r_blocked;

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Randomised scoreboard bench for turn_signal_conditioner, DIV=1 and DIV=4 instances side by side.
module tb_turn_signal_conditioner;

  localparam int DEB = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic btn_l = 1'b0;
  logic btn_r = 1'b0;

  always #5 clk = ~clk;

  turn_signal_conditioner_if if1 ();
  turn_signal_conditioner_if if4 ();

  assign if1.btnLeft  = btn_l;
  assign if1.btnRight = btn_r;
  assign if4.btnLeft  = btn_l;
  assign if4.btnRight = btn_r;

  turn_signal_conditioner #(.DIV(1), .DEBOUNCE(DEB)) u_div1 (.clk(clk), .reset(reset), .bus(if1.slave));
  turn_signal_conditioner #(.DIV(4), .DEBOUNCE(DEB)) u_div4 (.clk(clk), .reset(reset), .bus(if4.slave));

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: k=0 is DIV=1, k=1 is DIV=4; side 0 left, 1 right.
  int       n_edges = 0;
  bit       hist_l[$];
  bit       hist_r[$];
  bit       m_deb[2][2];
  int       m_own[2];
  bit       tq[4][$];
  bit [5:0] sb[$];

  function automatic int div_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  // Expected response after each edge, computed from the behavioural rules.
  always @(posedge clk or negedge reset) begin
    bit       s2[2];
    bit       old_deb[2];
    int       old_own;
    int       own;
    int       idx;
    bit       all_dis;
    bit       blk;
    bit [5:0] exp_v;
    if (!reset) begin
      n_edges = 0;
      hist_l.delete();
      hist_r.delete();
      for (int k = 0; k < 2; k++) begin
        m_own[k] = 0;
        m_deb[k][0] = 1'b0;
        m_deb[k][1] = 1'b0;
      end
      for (int q = 0; q < 4; q++) tq[q].delete();
      sb.delete();
    end else begin
      n_edges++;
      hist_l.push_back(btn_l);
      hist_r.push_back(btn_r);
      if (hist_l.size() > 3) void'(hist_l.pop_front());
      if (hist_r.size() > 3) void'(hist_r.pop_front());
      s2[0] = (hist_l.size() == 3) ? hist_l[0] : 1'b0;
      s2[1] = (hist_r.size() == 3) ? hist_r[0] : 1'b0;
      exp_v = '0;
      for (int k = 0; k < 2; k++) begin
        old_own    = m_own[k];
        old_deb[0] = m_deb[k][0];
        old_deb[1] = m_deb[k][1];
        case (old_own)
          0:       own = old_deb[0] ? 1 : (old_deb[1] ? 2 : 0);
          1:       own = old_deb[0] ? 1 : 0;
          default: own = old_deb[1] ? 2 : 0;
        endcase
        m_own[k] = own;
        if ((n_edges % div_of(k)) == 0) begin
          for (int sd = 0; sd < 2; sd++) begin
            idx = k * 2 + sd;
            tq[idx].push_back(s2[sd]);
            if (tq[idx].size() > DEB) void'(tq[idx].pop_front());
            all_dis = (tq[idx].size() == DEB);
            for (int j = 0; j < tq[idx].size(); j++)
              if (tq[idx][j] == m_deb[k][sd]) all_dis = 1'b0;
            if (all_dis) m_deb[k][sd] = ~m_deb[k][sd];
          end
        end
        blk = (m_deb[k][0] && !old_deb[0] && old_own == 2) ||
              (m_deb[k][1] && !old_deb[1] && old_own == 1);
        exp_v[k*3 +: 3] = {own == 1, own == 2, blk};
      end
      sb.push_back(exp_v);
    end
  end

  // Monitor: compares DUT outputs against the scoreboard away from the edge.
  always @(negedge clk) begin
    bit [5:0] got;
    bit [5:0] want;
    bit       ok;
    got = {if4.eLeft, if4.eRight, if4.blocked, if1.eLeft, if1.eRight, if1.blocked};
    ok  = 1'b1;
    if (!reset || n_edges == 0) begin
      want = '0;
    end else if (sb.size() == 0) begin
      want = '0;
      ok   = 1'b0;
      $display("FAIL sb_underflow at %0t: no expected entry, outputs=%b", $time, got);
    end else begin
      want = sb.pop_front();
    end
    vectors++;
    if (!ok || got !== want) begin
      miscompares++;
      if (ok)
        $display("FAIL outputs at %0t edge %0d: got {eL,eR,blk}x2=%b required %b", $time, n_edges, got, want);
    end
  end

  task automatic apply(input bit l, input bit r, input int cyc);
    repeat (cyc) begin
      @(negedge clk);
      btn_l = l;
      btn_r = r;
    end
  endtask

  task automatic async_reset();
    bit [5:0] got;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    got = {if4.eLeft, if4.eRight, if4.blocked, if1.eLeft, if1.eRight, if1.blocked};
    vectors++;
    if (got !== 6'b0) begin
      miscompares++;
      $display("FAIL async_reset at %0t: outputs=%b required 000000", $time, got);
    end
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    int unsigned mode;
    int unsigned len;
    bit          v;
    reset = 1'b0;
    btn_l = 1'b1;
    btn_r = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    apply(1, 1, 30);
    apply(0, 1, 30);
    apply(0, 0, 30);
    apply(1, 0, 30);
    apply(0, 0, 30);
    for (int t = 0; t < 4; t++) apply(t[0] ? 1'b0 : 1'b1, 0, 1);
    apply(0, 0, 20);
    apply(0, 1, 2);
    apply(0, 0, 20);
    apply(1, 0, 30);
    apply(1, 1, 30);
    apply(0, 1, 30);
    apply(0, 0, 30);
    apply(1, 0, 8);
    async_reset();
    apply(1, 0, 30);
    apply(0, 0, 30);

    for (int s = 0; s < 220; s++) begin
      mode = $urandom_range(0, 9);
      case (mode)
        0, 1, 2, 3: apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 40)));
        4, 5: begin
          len = $urandom_range(2, 8);
          v   = btn_l;
          for (int t = 0; t < int'(len); t++) begin
            v = ~v;
            if (mode == 4) apply(v, btn_r, 1);
            else           apply(btn_l, v, 1);
          end
          apply(btn_l, btn_r, int'($urandom_range(5, 30)));
        end
        6: begin
          apply(~btn_l, btn_r, int'($urandom_range(1, 2)));
          apply(~btn_l, btn_r, 25);
        end
        7: begin
          apply(0, 0, 30);
          apply(1, 1, 40);
          apply(0, 1, 40);
        end
        8: begin
          apply(0, 1, 30);
          apply(1, 1, 30);
          apply(1, 0, 30);
        end
        default: begin
          if ($urandom_range(0, 2) == 0) async_reset();
          apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(5, 30)));
        end
      endcase
    end
    apply(0, 0, 30);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
